// File: rtl/assoc_cache.sv
// N-way set-associative write-back data cache with age-counter LRU and an
// internal write-back/refill controller between the CPU port and a word-wide memory port.
module assoc_cache #(
    parameter int WAYS       = 4,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [2:0]           u_b_h_w,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    output logic                 cpu_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_dout,
    input  logic [31:0]          mem_din,
    input  logic                 mem_ack,
    input  logic                 inv_all,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt,
    output logic [1:0]           fsm_state
);
    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(LINE_WORDS);
    localparam int AW = $clog2(WAYS);
    localparam int TW = ADDR_BITS - IW - WW - 2;

    typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_t;
    state_t state, state_nx;

    logic [TW-1:0]   tags  [WAYS][SETS];
    logic [31:0]     data  [WAYS][SETS][LINE_WORDS];
    logic [WAYS-1:0] valid [SETS];
    logic [WAYS-1:0] dirty [SETS];
    logic [AW-1:0]   age   [SETS][WAYS];

    logic                 r_we;
    logic [2:0]           r_ubhw;
    logic [ADDR_BITS-1:0] r_addr;
    logic [31:0]          r_din;
    logic [WW-1:0]        cnt;
    logic [AW-1:0]        vic;
    logic                 refill;

    logic [TW-1:0] r_tag;
    logic [IW-1:0] r_idx;
    logic [WW-1:0] r_word;
    assign r_tag  = r_addr[ADDR_BITS-1 -: TW];
    assign r_idx  = r_addr[WW+2 +: IW];
    assign r_word = r_addr[2 +: WW];
    assign fsm_state = state;

    logic          hit, vic_found;
    logic [AW-1:0] hit_way, vic_sel;
    logic [31:0]   hit_word, ld_data, st_data;
    logic [15:0]   ld_half;
    logic [7:0]    ld_byte;
    logic [3:0]    st_be;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        vic_found = 1'b0;
        vic_sel   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[r_idx][w] && tags[w][r_idx] == r_tag) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
        end
        // Lowest invalid way first; otherwise the oldest line in the set.
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid[r_idx][w]) begin
                vic_found = 1'b1;
                vic_sel   = AW'(w);
            end
        end
        if (!vic_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[r_idx][w] == AW'(WAYS-1)) vic_sel = AW'(w);
            end
        end
    end

    always_comb begin
        hit_word = data[hit_way][r_idx][r_word];
        ld_half  = r_addr[1] ? hit_word[31:16] : hit_word[15:0];
        ld_byte  = hit_word[{r_addr[1:0], 3'b000} +: 8];
        if (r_ubhw[1])      ld_data = hit_word;
        else if (r_ubhw[0]) ld_data = r_ubhw[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        else                ld_data = r_ubhw[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        if (r_ubhw[1]) begin
            st_data = r_din;
            st_be   = 4'hF;
        end else if (r_ubhw[0]) begin
            st_data = {2{r_din[15:0]}};
            st_be   = r_addr[1] ? 4'hC : 4'h3;
        end else begin
            st_data = {4{r_din[7:0]}};
            st_be   = 4'b0001 << r_addr[1:0];
        end
    end

    // Memory port is a pure function of state/cnt, so it drops with the async reset.
    always_comb begin
        mem_req  = (state == WB) || (state == FILL);
        mem_we   = (state == WB);
        mem_addr = '0;
        mem_dout = '0;
        if (state == WB) begin
            mem_addr = {tags[vic][r_idx], r_idx, cnt, 2'b00};
            mem_dout = data[vic][r_idx][cnt];
        end else if (state == FILL) begin
            mem_addr = {r_tag, r_idx, cnt, 2'b00};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cpu_req) state_nx = LOOKUP;
            LOOKUP:  if (!hit) state_nx = dirty[r_idx][vic_sel] ? WB : FILL;
                     else state_nx = IDLE;
            WB:      if (mem_ack && (&cnt)) state_nx = FILL;
            FILL:    if (mem_ack && (&cnt)) state_nx = LOOKUP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            vic      <= '0;
            refill   <= 1'b0;
            r_we     <= 1'b0;
            r_ubhw   <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            cpu_ack  <= 1'b0;
            dout     <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state   <= state_nx;
            cpu_ack <= 1'b0;
            case (state)
                IDLE: if (cpu_req) begin
                    r_we   <= cpu_we;
                    r_ubhw <= u_b_h_w;
                    r_addr <= addr;
                    r_din  <= din;
                    refill <= 1'b0;
                    cnt    <= '0;
                end
                LOOKUP: if (hit) begin
                    cpu_ack <= 1'b1;
                    dout    <= ld_data;
                    // The re-lookup after a refill completes the original miss.
                    if (!refill && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    vic <= vic_sel;
                    cnt <= '0;
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                end
                WB:   if (mem_ack) cnt <= cnt + 1'b1;
                FILL: if (mem_ack) begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) refill <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= '0;
            end
        end else if (state == IDLE && !cpu_req && inv_all) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= '0;
            end
        end else if (state == LOOKUP && hit) begin
            for (int w = 0; w < WAYS; w++) begin
                if (valid[r_idx][w] && age[r_idx][w] < age[r_idx][hit_way])
                    age[r_idx][w] <= age[r_idx][w] + 1'b1;
            end
            age[r_idx][hit_way] <= '0;
            if (r_we) dirty[r_idx][hit_way] <= 1'b1;
        end else if (state == LOOKUP) begin
            // The victim is invalid while its data is being overwritten.
            valid[r_idx][vic_sel] <= 1'b0;
        end else if (state == FILL && mem_ack && (&cnt)) begin
            valid[r_idx][vic] <= 1'b1;
            dirty[r_idx][vic] <= 1'b0;
            // Enter as oldest so the following hit ages every other valid way by one.
            age[r_idx][vic]   <= AW'(WAYS-1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            data[vic][r_idx][cnt] <= mem_din;
            if (&cnt) tags[vic][r_idx] <= r_tag;
        end else if (state == LOOKUP && hit && r_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) data[hit_way][r_idx][r_word][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: memory responder with configurable latency,
// transfer log, and hand-computed expectations for each access.
module tb_assoc_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [2:0]  u_b_h_w = 3'b010;
    logic [31:0] addr = '0, din = '0;
    logic [31:0] dout;
    logic        cpu_ack;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_dout;
    logic [31:0] mem_din = '0;
    logic        mem_ack = 1'b0;
    logic        inv_all = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;
    logic [1:0]  fsm_state;

    assoc_cache #(.WAYS(4), .SETS(32), .LINE_WORDS(4), .ADDR_BITS(32)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .u_b_h_w(u_b_h_w),
        .addr(addr), .din(din), .dout(dout), .cpu_ack(cpu_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ack(mem_ack), .inv_all(inv_all),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory model and responder: decides mem_ack on the falling edge so the DUT samples it next rising edge.
    logic [31:0] mem_model [1024];
    logic        log_we   [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    int          mem_lat = 1;
    int          wait_cnt = 0;
    int          viol = 0;
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0, prev_dout = '0;

    always @(negedge clk) begin
        if (mem_req && prev_req && !prev_ack && (mem_addr != prev_addr || mem_dout != prev_dout))
            viol++;
        if (mem_req) begin
            mem_din = mem_model[mem_addr[11:2]];
            if (wait_cnt >= mem_lat - 1) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                log_we.push_back(mem_we);
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_we ? mem_dout : mem_din);
                if (mem_we) mem_model[mem_addr[11:2]] = mem_dout;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
        prev_dout = mem_dout;
    end

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic check_burst(input string tag, input int start, input logic we, input logic [31:0] base);
        int n;
        n = (log_addr.size() >= start + 4) ? 4 : log_addr.size() - start;
        if (n < 0) n = 0;
        check({tag, "_len"}, 32'(n), 32'd4);
        for (int i = 0; i < n; i++) begin
            check({tag, "_we"}, 32'(log_we[start+i]), 32'(we));
            check({tag, "_addr"}, log_addr[start+i], base + 32'(4*i));
        end
    endtask

    task automatic access(input logic we, input logic [2:0] ubhw, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int cyc);
        cpu_req = 1'b1;
        cpu_we  = we;
        u_b_h_w = ubhw;
        addr    = a;
        din     = d;
        cyc     = 0;
        rd      = '0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cpu_ack) begin
                rd = dout;
                break;
            end
            if (cyc >= 500) begin
                check("ack_timeout", 32'd0, 32'd1);
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    localparam logic [2:0] LW = 3'b010, LH = 3'b001, LHU = 3'b101, LB = 3'b000, LBU = 3'b100;

    logic [31:0] rd;
    int          cyc, c_clean, c_dirty;

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'hC0DE0000 | 32'(i);

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_hits", hit_cnt, 32'd0);
        check("rst_misses", miss_cnt, 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Cold load, then a hit on the same word.
        clear_log();
        access(1'b0, LW, 32'h104, 32'h0, rd, cyc);
        check_burst("cold_fill", 0, 1'b0, 32'h100);
        check("cold_dout", rd, 32'hC0DE0041);
        check("cold_miss", miss_cnt, 32'd1);
        access(1'b0, LW, 32'h104, 32'h0, rd, cyc);
        check("hit_dout", rd, 32'hC0DE0041);
        check("hit_latency", 32'(cyc), 32'd2);
        check("hit_count", hit_cnt, 32'd1);

        // Sub-word stores and loads.
        access(1'b1, LW, 32'h40, 32'h8899AABB, rd, cyc);
        access(1'b1, LB, 32'h41, 32'h000000FF, rd, cyc);
        access(1'b0, LW, 32'h40, 32'h0, rd, cyc);
        check("lw_merged", rd, 32'h8899FFBB);
        access(1'b0, LH, 32'h42, 32'h0, rd, cyc);
        check("lh_sign", rd, 32'hFFFF8899);
        access(1'b0, LHU, 32'h42, 32'h0, rd, cyc);
        check("lhu_zero", rd, 32'h00008899);
        access(1'b0, LB, 32'h41, 32'h0, rd, cyc);
        check("lb_sign", rd, 32'hFFFFFFFF);
        access(1'b0, LBU, 32'h40, 32'h0, rd, cyc);
        check("lbu_zero", rd, 32'h000000BB);
        check("sub_hits", hit_cnt, 32'd7);
        check("sub_misses", miss_cnt, 32'd2);

        // LRU: tags 1..4 in set 0, touch tag 1, tag 5 must evict tag 2.
        access(1'b0, LW, 32'h200, 32'h0, rd, cyc);
        access(1'b0, LW, 32'h400, 32'h0, rd, cyc);
        access(1'b0, LW, 32'h600, 32'h0, rd, cyc);
        access(1'b0, LW, 32'h800, 32'h0, rd, cyc);
        access(1'b0, LW, 32'h200, 32'h0, rd, cyc);
        clear_log();
        access(1'b0, LW, 32'hA00, 32'h0, rd, cyc);
        c_clean = cyc;
        check_burst("t5_fill", 0, 1'b0, 32'hA00);
        check("t5_dout", rd, 32'hC0DE0280);
        access(1'b0, LW, 32'h200, 32'h0, rd, cyc);
        check("t1_kept", hit_cnt, 32'd9);
        access(1'b0, LW, 32'h400, 32'h0, rd, cyc);
        check("t2_evicted", miss_cnt, 32'd8);

        // Dirty write-back: dirty tag 2, age it to oldest, evict with tag 3.
        access(1'b1, LW, 32'h404, 32'h12345678, rd, cyc);
        access(1'b0, LW, 32'h800, 32'h0, rd, cyc);
        access(1'b0, LW, 32'hA00, 32'h0, rd, cyc);
        access(1'b0, LW, 32'h200, 32'h0, rd, cyc);
        check("pre_wb_hits", hit_cnt, 32'd13);
        clear_log();
        access(1'b0, LW, 32'h600, 32'h0, rd, cyc);
        c_dirty = cyc;
        check_burst("wb", 0, 1'b1, 32'h400);
        check("wb_d0", log_data.size() > 0 ? log_data[0] : 32'hX, 32'hC0DE0100);
        check("wb_d1", log_data.size() > 1 ? log_data[1] : 32'hX, 32'h12345678);
        check("wb_d3", log_data.size() > 3 ? log_data[3] : 32'hX, 32'hC0DE0103);
        check_burst("wb_fill", 4, 1'b0, 32'h600);
        check("wb_dout", rd, 32'hC0DE0180);
        check("wb_extra_cycles", 32'(c_dirty - c_clean), 32'd4);
        access(1'b0, LW, 32'h404, 32'h0, rd, cyc);
        check("wb_reload", rd, 32'h12345678);
        check("wb_misses", miss_cnt, 32'd10);

        // Backpressure: one ack every third cycle.
        mem_lat = 3;
        viol = 0;
        clear_log();
        access(1'b0, LW, 32'h150, 32'h0, rd, cyc);
        check_burst("bp_fill", 0, 1'b0, 32'h150);
        check("bp_dout", rd, 32'hC0DE0054);
        check("bp_stable", 32'(viol), 32'd0);
        mem_lat = 1;

        // Invalidate everything; counters survive.
        inv_all = 1'b1;
        @(negedge clk);
        inv_all = 1'b0;
        clear_log();
        access(1'b0, LW, 32'h150, 32'h0, rd, cyc);
        check("inv_refill_len", 32'(log_addr.size()), 32'd4);
        check("inv_misses", miss_cnt, 32'd12);
        check("inv_hits", hit_cnt, 32'd13);

        // Asynchronous reset while FILL is on word 2.
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        u_b_h_w = LW;
        addr    = 32'h300;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
            if (mem_req && mem_addr == 32'h308) break;
        end
        check("rst_reach_w2", mem_addr, 32'h308);
        rst = 1'b0;
        #1;
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_state", 32'(fsm_state), 32'd0);
        check("abort_misses", miss_cnt, 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_log();
        access(1'b0, LW, 32'h300, 32'h0, rd, cyc);
        check_burst("abort_refill", 0, 1'b0, 32'h300);
        check("abort_dout", rd, 32'hC0DE00C0);
        check("abort_remiss", miss_cnt, 32'd1);
        check("abort_hits", hit_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative write-back data cache with an integrated miss controller. It sits between the pipeline's memory stage and the word-wide main-memory port, and succeeds the fixed 2-way, externally sequenced cache array. Compared with that array it adds configurable associativity, sets and line length; age-counter LRU replacement across any number of ways; an internal write-back/refill state machine with a request/acknowledge handshake on both sides; and hit/miss statistics counters.

## Interface
- WAYS, 4, associativity; power of two, ≥2
- SETS, 32, number of sets; power of two
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2
- ADDR_BITS, 32, byte address width; tag width = ADDR_BITS − log2(SETS) − log2(LINE_WORDS) − 2
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  access request; held stable with addr/din/cpu_we/u_b_h_w until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- u_b_h_w  in  3  [1] word, else [0] half, else byte; [2] zero-extend loads
- addr  in  ADDR_BITS  byte address
- din  in  32  store data, right-aligned
- dout  out  32  load data, extended per u_b_h_w; valid while cpu_ack = 1
- cpu_ack  out  1  one-cycle completion pulse
- mem_req, mem_we  out  1 each  memory word request; write enable
- mem_addr  out  ADDR_BITS  word-aligned memory address
- mem_dout  out  32  write-back data
- mem_din  in  32  refill data, sampled when mem_ack = 1
- mem_ack  in  1  memory completes the current word
- inv_all  in  1  single-cycle pulse, honoured only in IDLE: clear every valid, dirty and age bit
- hit_cnt, miss_cnt  out  32 each  saturating statistics counters

## Operation
- Address split: tag | index (log2 SETS) | word (log2 LINE_WORDS) | byte (2).
- States: IDLE, LOOKUP, WB, FILL.
- IDLE: if cpu_req = 1, latch the request and go to LOOKUP. If inv_all = 1 and cpu_req = 0, clear all valid, dirty and age state; stay in IDLE. If both are 1, cpu_req wins and inv_all is dropped.
- LOOKUP, hit (valid and tag equal in exactly one way):
  - Load: select the addressed word, half (addr[1]) or byte (addr[1:0]); sign- or zero-extend into dout.
  - Store: merge din into the addressed bytes; set dirty.
  - Either case: pulse cpu_ack, increment hit_cnt, update LRU, return to IDLE.
- LOOKUP, miss:
  - Increment miss_cnt.
  - Victim is the lowest-numbered invalid way; if all ways are valid, the way with age = WAYS−1.
  - Next state: WB if the victim is dirty, else FILL.
- WB: mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, cnt, 00}, mem_dout = victim word cnt. Each mem_ack increments cnt. After LINE_WORDS acks, clear cnt and go to FILL.
- FILL: mem_req = 1, mem_we = 0, mem_addr = {req tag, index, cnt, 00}. Each mem_ack writes mem_din to word cnt. On the last ack, write the tag, set valid, clear dirty, and go to LOOKUP, which then hits.
- LRU: each line has a log2(WAYS)-bit age; all valid ages within a set are distinct. On a hit or fill-hit of way w: ages below age(w) increment, age(w) becomes 0, others are unchanged.
- Misaligned accesses: word access ignores addr[1:0]; half access ignores addr[0].
- Counters saturate at 2^32−1. They are cleared only by rst, not by inv_all.

## Timing
- Reset values: state IDLE; all valid, dirty and age bits 0; dout = 0; cpu_ack = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_dout = 0; hit_cnt = 0; miss_cnt = 0. Data and tag arrays are not reset.
- Hit latency: cpu_req sampled at edge 0, cpu_ack high in the cycle after edge 1.
- Back-to-back: if cpu_req is still high in the cpu_ack cycle, it is taken as a new request.
- Clean miss: 1 + LINE_WORDS·(memory latency) + 1 (re-LOOKUP) cycles. A dirty miss adds the WB phase of the same length.
- mem_req is held continuously through WB and FILL. mem_addr and mem_dout change only on the edge that samples mem_ack. A zero-wait memory gives one word per cycle.
- Reset mid-WB or mid-FILL: asynchronous abort. mem_req drops immediately; the partially filled line stays invalid.

## Test plan
- Cold load: WAYS = 4, LINE_WORDS = 4, load word 0x0000_0104 → 4 FILL reads at 0x100–0x10C, then dout = mem[0x104], miss_cnt = 1; repeat the load → 2-cycle hit, hit_cnt = 1.
- Sub-word store/load: sw 0x8899AABB at 0x40, sb 0xFF at 0x41 → lw returns 0x8899FFBB; lh at 0x42 returns 0xFFFF8899; lhu at 0x42 returns 0x00008899.
- LRU eviction: fill 4 ways of set 0 with tags 1–4 and touch tag 1 → a tag-5 miss evicts tag 2.
- Dirty write-back: store to tag 2, then force its eviction → 4 WB writes carrying the old tag's address and the stored data, followed by 4 FILL reads.
- Memory backpressure: mem_ack every 3rd cycle → mem_addr and mem_req stable between acks, data correct.
- Async reset asserted during FILL word 2 → mem_req falls without a clock edge; a re-access to the same address misses again.
